// File: rtl/bram_mem.sv
// Burst-read / single-write responder backed by on-chip RAM.
// It sits at the memory end of the arbiter interface where the sdram used to be.
// A read returns BURST consecutive words, starting at the request address and
// wrapping around the end of the RAM.
//
// state | meaning
// IDLE  | waiting for req; a request is accepted at any edge with req=1
// WACK  | write has been stored; one turnaround cycle before the next request
// RD    | issuing reads for burst words 1..BURST-1, one per cycle
module bram_mem #(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int IN    = 2,
    parameter int BURST = 8,
    parameter int MN    = 12
) (
    input  logic          clkSYS,
    input  logic          reset,
    input  logic          req,
    input  logic          wr,
    input  logic [AN-1:0] addr,
    input  logic [DN-1:0] data,
    input  logic [IN-1:0] id,
    output logic          ack,
    output logic [DN-1:0] mem,
    output logic [IN-1:0] mem_id,
    output logic          valid
);

    localparam int CW = $clog2(BURST);

    typedef enum logic [1:0] {IDLE, WACK, RD} state_t;

    state_t        state;
    logic [DN-1:0] ram [0:(1<<MN)-1];
    logic [DN-1:0] ram_q;
    logic [MN-1:0] ptr;
    logic [MN-1:0] raddr;
    logic [CW-1:0] cnt;
    logic [IN-1:0] burst_id;
    logic          rd_vld;
    logic [IN-1:0] rd_id;
    logic          accept;
    logic          we;
    logic          re;

    // Word 0 of a burst is read at the accept edge itself, so it must use the
    // live address; later words come from the captured pointer.
    assign accept = (state == IDLE) && req;
    assign we     = accept && wr;
    assign re     = (accept && !wr) || (state == RD);
    assign raddr  = (state == IDLE) ? addr[MN-1:0] : ptr;

    // RAM array: synchronous read, read-before-write, contents never reset.
    always_ff @(posedge clkSYS) begin
        if (we) begin
            ram[addr[MN-1:0]] <= data;
        end
        ram_q <= ram[raddr];
    end

    // Request FSM: acceptance, burst pointer/down-counter and read-issue tagging.
    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ack      <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
            burst_id <= '0;
            rd_vld   <= 1'b0;
            rd_id    <= '0;
        end else begin
            ack    <= accept;
            rd_vld <= re;
            rd_id  <= (state == IDLE) ? id : burst_id;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (wr) begin
                            state <= WACK;
                        end else begin
                            state    <= RD;
                            ptr      <= addr[MN-1:0] + MN'(1);
                            burst_id <= id;
                            cnt      <= CW'(BURST - 1);
                        end
                    end
                end
                WACK: begin
                    state <= IDLE;
                end
                RD: begin
                    ptr <= ptr + MN'(1);
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output register: presents each issued read beat; holds the last beat otherwise.
    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            mem    <= '0;
            mem_id <= '0;
        end else begin
            valid <= rd_vld;
            if (rd_vld) begin
                mem    <= ram_q;
                mem_id <= rd_id;
            end
        end
    end

endmodule

// File: tb/tb_bram_mem.sv
// Self-checking bench for bram_mem with default parameters (BURST=8, MN=12).
// Inputs change and outputs are sampled on the falling edge.
module tb_bram_mem;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  id;
    logic        ack;
    logic [15:0] mem;
    logic [1:0]  mem_id;
    logic        valid;

    int total;
    int passed;
    int acks;
    int vcount;
    int run;
    int max_run;

    logic [15:0] model [0:4095];
    logic [15:0] sb_data[$];
    logic [1:0]  sb_id[$];

    bram_mem dut (
        .clkSYS (clk),
        .reset  (reset),
        .req    (req),
        .wr     (wr),
        .addr   (addr),
        .data   (data),
        .id     (id),
        .ack    (ack),
        .mem    (mem),
        .mem_id (mem_id),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every beat is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [15:0] ed;
            logic [1:0]  ei;
            vcount++;
            run++;
            if (run > max_run) max_run = run;
            total++;
            if (sb_data.size() == 0) begin
                $display("FAIL beat_unexpected: mem=%h mem_id=%0d, required no beat", mem, mem_id);
            end else begin
                ed = sb_data.pop_front();
                ei = sb_id.pop_front();
                if (mem !== ed || mem_id !== ei)
                    $display("FAIL beat_data: mem=%h mem_id=%0d, required mem=%h mem_id=%0d", mem, mem_id, ed, ei);
                else
                    passed++;
            end
        end else begin
            run = 0;
        end
        if (ack === 1'b1) acks++;
    end

    // Single write; called and returns just after a falling edge with the DUT idle.
    task automatic wr_word(input logic [23:0] a, input logic [15:0] d);
        req = 1'b1; wr = 1'b1; addr = a; data = d;
        @(posedge clk);
        model[a[11:0]] = d;
        @(negedge clk);
        total++;
        if (ack !== 1'b1) $display("FAIL wr_ack_high: ack=%b, required 1", ack);
        else passed++;
        req = 1'b0; wr = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0) $display("FAIL wr_ack_low: ack=%b, required 0", ack);
        else passed++;
    endtask

    // Issue a read burst; returns at the falling edge of the ack cycle.
    task automatic rd_issue(input logic [23:0] a, input logic [1:0] i);
        logic [11:0] ix;
        req = 1'b1; wr = 1'b0; addr = a; id = i;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            ix = a[11:0] + 12'(k);
            sb_data.push_back(model[ix]);
            sb_id.push_back(i);
        end
        @(negedge clk);
        total++;
        if (ack !== 1'b1) $display("FAIL rd_ack: ack=%b, required 1", ack);
        else passed++;
        req = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; data = '0; id = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ack !== 1'b0 || valid !== 1'b0)
            $display("FAIL reset_ctrl: ack=%b valid=%b, required 0 0", ack, valid);
        else passed++;
        total++;
        if (mem !== 16'h0 || mem_id !== 2'd0)
            $display("FAIL reset_data: mem=%h mem_id=%0d, required 0 0", mem, mem_id);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int k = 1; k < 8; k++) wr_word(24'h000010 + 24'(k), 16'h5000 + 16'(k));
        wr_word(24'h000010, 16'h1234);
        rd_issue(24'h000010, 2'd2);
        total++;
        if (valid !== 1'b0) $display("FAIL basic_lat_early: valid=%b, required 0", valid);
        else passed++;
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b1 || ack !== 1'b0)
                $display("FAIL basic_beat_cycle%0d: valid=%b ack=%b, required 1 0", c, valid, ack);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b0) $display("FAIL basic_lat_end: valid=%b, required 0", valid);
        else passed++;
        total++;
        if (mem !== model[12'h017] || mem_id !== 2'd2)
            $display("FAIL basic_hold: mem=%h mem_id=%0d, required %h 2", mem, mem_id, model[12'h017]);
        else passed++;
        drain();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) begin
            logic [11:0] a;
            a = 12'hFFE + 12'(k);
            wr_word({12'h000, a}, {4'h0, a});
        end
        rd_issue(24'h000FFE, 2'd1);
        drain();
        rd_issue(24'h7A0FFE, 2'd3);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            wr_word(24'h000100 + 24'(k), 16'h1100 + 16'(k));
            wr_word(24'h000200 + 24'(k), 16'h2200 + 16'(k));
        end
        acks = 0; vcount = 0; max_run = 0;
        req = 1'b1; wr = 1'b0; addr = 24'h000100; id = 2'd0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            sb_data.push_back(model[12'h100 + 12'(k)]);
            sb_id.push_back(2'd0);
        end
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        req = 1'b1; addr = 24'h000200; id = 2'd3;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            sb_data.push_back(model[12'h200 + 12'(k)]);
            sb_id.push_back(2'd3);
        end
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        drain();
        total++;
        if (acks != 2) $display("FAIL b2b_acks: acks=%0d, required 2", acks);
        else passed++;
        total++;
        if (vcount != 16 || max_run != 16)
            $display("FAIL b2b_stream: beats=%0d longest_run=%0d, required 16 16", vcount, max_run);
        else passed++;
    endtask

    task automatic test_drain_write();
        for (int k = 0; k < 8; k++) wr_word(24'h00001C + 24'(k), 16'hC01C + 16'(k));
        rd_issue(24'h00001C, 2'd1);
        repeat (7) @(negedge clk);
        wr_word(24'h000020, 16'hDEAD);
        drain();
        rd_issue(24'h00001C, 2'd2);
        drain();
        total++;
        if (model[12'h020] !== 16'hDEAD || sb_data.size() != 0)
            $display("FAIL drain_sb: pending=%0d, required 0", sb_data.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) wr_word(24'h000400 + 24'(k), 16'h4A00 + 16'(k));
        rd_issue(24'h000400, 2'd3);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (valid !== 1'b0 || mem !== 16'h0 || mem_id !== 2'd0 || ack !== 1'b0)
            $display("FAIL midreset_clear: valid=%b mem=%h mem_id=%0d ack=%b, required 0 0 0 0", valid, mem, mem_id, ack);
        else passed++;
        sb_data.delete();
        sb_id.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        vcount = 0;
        drain();
        total++;
        if (vcount != 0) $display("FAIL midreset_nobeats: beats=%0d, required 0", vcount);
        else passed++;
        rd_issue(24'h000400, 2'd1);
        drain();
    endtask

    task automatic test_write_stream();
        for (int k = 0; k < 8; k++) wr_word(24'h000300 + 24'(k), 16'hA000 + 16'(k));
        for (int c = 0; c < 8; c++) begin
            req = 1'b1; wr = 1'b1; addr = 24'h000300 + 24'(c); data = 16'hB000 + 16'(c);
            @(posedge clk);
            if (c % 2 == 0) model[12'h300 + 12'(c)] = 16'hB000 + 16'(c);
            @(negedge clk);
            total++;
            if (ack !== ((c % 2 == 0) ? 1'b1 : 1'b0))
                $display("FAIL wstream_ack%0d: ack=%b, required %b", c, ack, (c % 2 == 0));
            else passed++;
        end
        req = 1'b0; wr = 1'b0;
        @(negedge clk);
        rd_issue(24'h000300, 2'd0);
        drain();
    endtask

    initial begin
        total = 0; passed = 0; acks = 0; vcount = 0; run = 0; max_run = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_drain_write();
        test_reset_mid();
        test_write_stream();
        total++;
        if (sb_data.size() != 0) $display("FAIL sb_leftover: pending=%0d, required 0", sb_data.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bram_mem.md
BRAM_MEM -- requirements
Module: bram_mem

Interface
REQ-001 The module SHALL have parameter AN, default 24, meaning the request address width.
REQ-002 The module SHALL have parameter DN, default 16, meaning the data word width.
REQ-003 The module SHALL have parameter IN, default 2, meaning the requester id width.
REQ-004 The module SHALL have parameter BURST, default 8, meaning the number of words returned per read request; legal values are 2 to 64.
REQ-005 The module SHALL have parameter MN, default 12, meaning log2 of the memory depth in words.
REQ-006 The module SHALL have port clkSYS, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port req, input, 1 bit: request pending from the arbiter.
REQ-009 The module SHALL have port wr, input, 1 bit: 1 selects a write request, 0 selects a read request.
REQ-010 The module SHALL have port addr, input, AN bits: word address of the request.
REQ-011 The module SHALL have port data, input, DN bits: write data.
REQ-012 The module SHALL have port id, input, IN bits: id of the requester.
REQ-013 The module SHALL have port ack, output, 1 bit: request accepted.
REQ-014 The module SHALL have port mem, output, DN bits: read data beat.
REQ-015 The module SHALL have port mem_id, output, IN bits: id tag of the current read beat.
REQ-016 The module SHALL have port valid, output, 1 bit: mem and mem_id hold a valid read beat.

Function
REQ-017 The module SHALL act as the responder end of the arbiter memory interface, in place of the sdram, backed by on-chip RAM of 2^MN x DN words.
REQ-018 The module SHALL use only addr[MN-1:0]; higher address bits are ignored.
REQ-019 The module SHALL have states IDLE, WACK and RD.
REQ-020 Acceptance SHALL occur only at a clock edge where state is IDLE and req is 1; that edge is E0.
REQ-021 Transitions at E0: wr=1 goes to WACK; wr=0 goes to RD.
REQ-022 ack SHALL be registered and high for exactly the one cycle following E0, for both reads and writes.
REQ-023 req SHALL be ignored in every state other than IDLE, including at edge E0+1 while the requester is still dropping req.
REQ-024 Write: data SHALL be stored at addr[MN-1:0] at edge E0.
REQ-025 Write: WACK SHALL go to IDLE at E0+1.
REQ-026 Write: valid and mem SHALL be unaffected by a write.
REQ-027 Read: addr[MN-1:0] and id SHALL be captured at E0.
REQ-028 Read: the word at address (addr+k) mod 2^MN, for k = 0..BURST-1, SHALL be read at edge E0+k.
REQ-029 Read: the burst need not be aligned; wrap-around from 2^MN-1 to 0 is required.
REQ-030 Read: RD SHALL go to IDLE at edge E0+BURST-1, so the earliest next acceptance is at edge E0+BURST.
REQ-031 Read beat k SHALL be presented on mem with valid=1 and mem_id = the captured id in the cycle following edge E0+1+k.
REQ-032 A read burst's beats SHALL be contiguous, with no gaps.
REQ-033 Back-to-back reads SHALL produce a continuous valid stream, with mem_id changing at the burst boundary.
REQ-034 Read beats already issued SHALL drain through the output register even after the state has returned to IDLE; a new request may be accepted during the drain.
REQ-035 A write and a read of the same address at the same edge SHALL return the old data (read-before-write).
REQ-036 valid SHALL be 0 in every cycle without a beat; mem and mem_id SHALL hold their last value when valid=0.
REQ-037 Read latency SHALL be fixed: first beat 2 cycles after E0, last beat BURST+1 cycles after E0.

Reset
REQ-038 While reset=1, asynchronously: state=IDLE, ack=0, valid=0, mem=0, mem_id=0, and the burst counter and pipeline valid bits are cleared.
REQ-039 RAM contents SHALL NOT be reset and SHALL be preserved across reset.
REQ-040 Reset asserted mid-burst SHALL abort the burst, with no further valid beats after reset deasserts.
REQ-041 Reset deassertion SHALL be synchronised by the instantiating logic; the first acceptance is allowed at the first edge after deassertion.

Verification
REQ-042 Write 0x1234 to addr 0x000010, id 1; then read addr 0x000010, id 2 (BURST=8) -> ack is 1 cycle for each; 8 valid beats start 2 cycles after read E0; beat0=0x1234; mem_id=2 on all beats.
REQ-043 Preload words 0xFFE..0xFFF and 0x000..0x005 with values equal to their addresses; read addr 0x000FFE (MN=12) -> beats 0x0FFE, 0x0FFF, 0x0000..0x0005.
REQ-044 Requester holds req for 1 cycle after ack, reads issued back-to-back with ids 0 then 3 -> valid high for 16 consecutive cycles; mem_id is 0 for 8 beats then 3 for 8 beats; exactly 2 acks.
REQ-045 Write to addr 0x020 accepted at edge E0+8 while the read of 0x01C..0x023 is draining -> the read returns the old value at 0x020; a following read returns the new value.
REQ-046 Assert reset for 1 cycle during beat 3 of a burst -> valid=0 immediately and stays 0; a read after reset returns RAM contents unchanged.
REQ-047 Hold req=1 continuously with wr=1 -> exactly one write per 2 cycles; ack pattern 1,0,1,0.
